// File: rtl/led_pio_fader.sv
// led_pio_fader: 8-channel LED driver with per-channel brightness fade and 255-cycle PWM output
//   clk_clk     : system clock, all state on rising edge
//   reset_reset : synchronous active-high reset
//   pio_in      : LED command word, bit i = 1 requests channel i fully on
//   fade_en     : 1 = ramp one step per tick, 0 = snap to target
//   led_out     : registered PWM drive, 1 = lit
//   busy        : 1 while any channel level differs from its target
module led_pio_fader #(
  parameter int STEP_DIV = 50000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [7:0] pio_in,
  input  logic       fade_en,
  output logic [7:0] led_out,
  output logic       busy
);
  localparam int PW = $clog2(STEP_DIV + 1);
  localparam logic [PW-1:0] LAST = PW'(STEP_DIV - 1);
  logic [7:0]    r_pio_q;
  logic [7:0]    r_pwm;
  logic [7:0]    r_led;
  logic [7:0]    r_level [8];
  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic [7:0]    w_tgt   [8];
  logic [7:0]    w_next  [8];
  logic [7:0]    w_busy;
  assign w_tick  = r_presc == LAST;
  assign led_out = r_led;
  assign busy    = |w_busy;
  // Targets are all-ones or all-zeros, so stepping toward them can never wrap.
  always_comb
    for (int i = 0; i < 8; i++) begin
      w_tgt[i]  = {8{r_pio_q[i]}};
      w_busy[i] = r_level[i] != w_tgt[i];
      w_next[i] = !fade_en ? w_tgt[i] :
                  !w_tick ? r_level[i] :
                  r_level[i] < w_tgt[i] ? r_level[i] + 8'd1 :
                  r_level[i] > w_tgt[i] ? r_level[i] - 8'd1 : r_level[i];
    end
  always_ff @(posedge clk_clk)
    if (reset_reset) begin
      r_pio_q <= '0;
      r_pwm   <= '0;
      r_led   <= '0;
      r_presc <= '0;
      for (int i = 0; i < 8; i++) r_level[i] <= '0;
    end else begin
      r_pio_q <= pio_in;
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_pwm   <= r_pwm == 8'd254 ? '0 : r_pwm + 8'd1;
      for (int i = 0; i < 8; i++) begin
        r_led[i]   <= r_pwm < r_level[i];
        r_level[i] <= w_next[i];
      end
    end
endmodule

// File: tb/tb_led_pio_fader.sv
// tb_led_pio_fader: directed bench with a cycle-level behavioural model of the fader
module tb_led_pio_fader;
  localparam int SDA = 4;
  localparam int SDB = 300;
  logic       clk = 0;
  logic       rst_a = 1, fade_a = 1, rst_b = 1, fade_b = 1;
  logic [7:0] pio_a = 0, pio_b = 0;
  logic [7:0] led_a, led_b;
  logic       busy_a, busy_b;
  int         total = 0, bad = 0;
  always #5 clk = ~clk;
  led_pio_fader #(.STEP_DIV(SDA)) u_a (
    .clk_clk(clk), .reset_reset(rst_a), .pio_in(pio_a), .fade_en(fade_a), .led_out(led_a), .busy(busy_a));
  led_pio_fader #(.STEP_DIV(SDB)) u_b (
    .clk_clk(clk), .reset_reset(rst_b), .pio_in(pio_b), .fade_en(fade_b), .led_out(led_b), .busy(busy_b));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  // Model: m_cnt counts non-reset cycles since reset, so the PWM phase is m_cnt mod 255
  // and a tick falls wherever m_cnt mod STEP_DIV is STEP_DIV-1.
  int         m_cnt = 0;
  int         m_lvl [8];
  logic [7:0] m_q = 0, m_led = 0;
  logic       armed = 0;
  function automatic int step(int l, int t, bit tk, bit fe);
    return !fe ? t : !tk ? l : l < t ? l + 1 : l > t ? l - 1 : l;
  endfunction
  function automatic bit m_busy();
    for (int i = 0; i < 8; i++) if (m_lvl[i] != (m_q[i] ? 255 : 0)) return 1;
    return 0;
  endfunction
  always @(posedge clk) begin
    armed <= armed | rst_a;
    m_cnt <= rst_a ? 0 : m_cnt + 1;
    m_q   <= rst_a ? 8'h00 : pio_a;
    for (int i = 0; i < 8; i++) begin
      m_led[i] <= !rst_a && (m_cnt % 255 < m_lvl[i]);
      m_lvl[i] <= rst_a ? 0 : step(m_lvl[i], m_q[i] ? 255 : 0, m_cnt % SDA == SDA - 1, fade_a);
    end
  end
  always @(negedge clk)
    if (armed) begin
      chk("model_led", 32'(led_a), 32'(m_led));
      chk("model_busy", 32'(busy_a), 32'(m_busy()));
    end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    int ones, zb, oth, prev, ups;
    pio_a = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_led", 32'(led_a), 0);
      chk("rst_busy", 32'(busy_a), 0);
    end
    rst_a = 0;
    #1 chk("rel_busy", 32'(busy_a), 0);
    repeat (2) @(negedge clk);
    chk("rel2_busy", 32'(busy_a), 1);
    rst_a = 1; pio_a = 8'h01;
    @(negedge clk);
    rst_a = 0;
    repeat (40) @(negedge clk);
    chk("mdl_lvl40", m_lvl[0], 10);
    repeat (1000) @(negedge clk);
    chk("mdl_lvl255", m_lvl[0], 255);
    chk("fade_led", 32'(led_a), 1);
    chk("fade_busy", 32'(busy_a), 0);
    ones = 0;
    repeat (255) begin
      @(negedge clk);
      ones += led_a == 8'h01 ? 1 : 0;
    end
    chk("fade_hold", ones, 255);
    rst_a = 1; pio_a = 8'h01;
    @(negedge clk);
    rst_a = 0;
    for (int k = 0; k < 1000 && m_lvl[0] != 100; k++) @(negedge clk);
    chk("mdl_lvl100", m_lvl[0], 100);
    pio_a = 8'h00;
    for (int k = 0; k < 20 && m_lvl[0] == 100; k++) @(negedge clk);
    chk("rev_first", m_lvl[0], 99);
    prev = m_lvl[0]; ups = 0;
    for (int k = 0; k < 1000 && busy_a; k++) begin
      @(negedge clk);
      ups += m_lvl[0] > prev || m_lvl[0] > 100 ? 1 : 0;
      prev = m_lvl[0];
    end
    chk("rev_busy_fall", 32'(busy_a), 0);
    chk("rev_lvl0", m_lvl[0], 0);
    chk("rev_mono", ups, 0);
    @(negedge clk);
    chk("rev_led", 32'(led_a), 0);
    fade_a = 0; pio_a = 8'h00;
    repeat (3) @(negedge clk);
    pio_a = 8'h80;
    repeat (3) @(negedge clk);
    ones = 0; zb = 0;
    repeat (300) begin
      @(negedge clk);
      ones += led_a == 8'h80 ? 1 : 0;
      zb += busy_a ? 0 : 1;
    end
    chk("snap_led", ones, 300);
    chk("snap_busy", zb, 300);
    fade_a = 1; rst_a = 1; pio_a = 8'h01;
    @(negedge clk);
    rst_a = 0;
    for (int k = 0; k < 1000 && m_lvl[0] != 128; k++) @(negedge clk);
    chk("mdl_lvl128", m_lvl[0], 128);
    rst_a = 1;
    @(negedge clk);
    chk("mid_led", 32'(led_a), 0);
    chk("mid_busy", 32'(busy_a), 0);
    chk("mid_mdl", m_lvl[0], 0);
    rst_a = 0;
    repeat (3) @(negedge clk);
    chk("restart_3", m_lvl[0], 0);
    @(negedge clk);
    chk("restart_4", m_lvl[0], 1);
    repeat (4) @(negedge clk);
    chk("restart_8", m_lvl[0], 2);
    pio_b = 8'h01;
    @(negedge clk);
    rst_b = 0;
    repeat (10801) @(negedge clk);
    ones = 0;
    repeat (255) begin
      @(negedge clk);
      ones += led_b[0] ? 1 : 0;
    end
    chk("duty36", ones, 36);
    repeat (45) @(negedge clk);
    ones = 0; oth = 0; zb = 0;
    repeat (255) begin
      @(negedge clk);
      ones += led_b[0] ? 1 : 0;
      oth += led_b[7:1] != 0 ? 1 : 0;
      zb += busy_b ? 0 : 1;
    end
    chk("duty37", ones, 37);
    chk("duty_others", oth, 0);
    chk("duty_busy", zb, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
